// File: rtl/keypad_scanner.sv
// Row-strobed active-low keypad scanner: synchronizes the column pins, debounces
// whole scan frames and hands each accepted press to the consumer as a code.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int  NumRows        = 4,
    parameter int  NumCols        = 4,
    parameter int  ScanPeriod     = 1000,
    parameter int  DebounceFrames = 3,
    localparam int CodeW          = $clog2(NumRows * NumCols)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NumCols-1:0] cols_n,
    output logic [NumRows-1:0] rows_n,
    output logic               key_valid,
    output logic [CodeW-1:0]   key_code,
    input  logic               key_ready,
    output logic               key_down,
    output logic               key_overrun
);
    localparam int DwellW = $clog2(ScanPeriod);
    localparam int RowW   = $clog2(NumRows);
    localparam int DbW    = $clog2(DebounceFrames + 1);

    localparam logic [DwellW-1:0] DwellLast = DwellW'(ScanPeriod - 1);
    localparam logic [RowW-1:0]   RowLast   = RowW'(NumRows - 1);
    localparam logic [DbW-1:0]    DbDone    = DbW'(DebounceFrames);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

    logic [DwellW-1:0]  dwell_q, dwell_d;
    logic [NumRows-1:0] rows_n_q, rows_n_d;
    logic [RowW-1:0]    row_q, row_d;
    logic [NumCols-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         hits_q, hits_d;
    logic [CodeW-1:0]   code_acc_q, code_acc_d;
    state_e             state_q, state_d;
    logic [DbW-1:0]     db_cnt_q, db_cnt_d;
    logic [CodeW-1:0]   cand_q, cand_d;
    logic               valid_q, valid_d;
    logic [CodeW-1:0]   key_code_q, key_code_d;
    logic               overrun_q, overrun_d;

    logic               sample, frame_end, emit, accept, single, none;
    logic [1:0]         row_hits, base_hits, tot_hits;
    logic [2:0]         sum_hits;
    logic [CodeW-1:0]   row_code, base_code, tot_code;

    always_comb begin : scan_comb
        sample    = (dwell_q == DwellLast);
        frame_end = sample && (row_q == RowLast);
        dwell_d   = sample ? '0 : dwell_q + DwellW'(1);
        rows_n_d  = sample ? {rows_n_q[NumRows-2:0], rows_n_q[NumRows-1]} : rows_n_q;
        row_d     = row_q;
        if (sample) begin
            row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
        end
        sync1_d = cols_n;
        sync2_d = sync1_q;

        // Hit count saturates at 2: anything beyond one hit is simply MULTI.
        row_hits = '0;
        row_code = '0;
        for (int unsigned c = 0; c < NumCols; c++) begin
            if (!sync2_q[c]) begin
                if (row_hits != 2'd2) begin
                    row_hits = row_hits + 2'd1;
                end
                row_code = CodeW'(row_q) * CodeW'(NumCols) + CodeW'(c);
            end
        end
        base_hits  = (row_q == '0) ? 2'd0 : hits_q;
        base_code  = (row_q == '0) ? '0 : code_acc_q;
        sum_hits   = {1'b0, base_hits} + {1'b0, row_hits};
        tot_hits   = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
        tot_code   = (base_hits != 2'd0) ? base_code : row_code;
        hits_d     = sample ? tot_hits : hits_q;
        code_acc_d = sample ? tot_code : code_acc_q;
    end

    always_comb begin : fsm_comb
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        cand_d   = cand_q;
        emit     = 1'b0;
        single   = (tot_hits == 2'd1);
        none     = (tot_hits == 2'd0);
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (single) begin
                        cand_d   = tot_code;
                        db_cnt_d = DbW'(1);
                        state_d  = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (single && (tot_code == cand_q)) begin
                        db_cnt_d = db_cnt_q + DbW'(1);
                        if (db_cnt_d == DbDone) begin
                            state_d = HELD;
                            emit    = 1'b1;
                        end
                    end else if (single) begin
                        cand_d   = tot_code;
                        db_cnt_d = DbW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (none) begin
                        db_cnt_d = DbW'(1);
                        state_d  = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (none) begin
                        db_cnt_d = db_cnt_q + DbW'(1);
                        if (db_cnt_d == DbDone) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : out_comb
        accept     = valid_q && key_ready;
        valid_d    = valid_q;
        key_code_d = key_code_q;
        overrun_d  = overrun_q;
        if (emit) begin
            if (!valid_q || accept) begin
                valid_d    = 1'b1;
                key_code_d = cand_q;
                overrun_d  = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q    <= '0;
            rows_n_q   <= {{(NumRows-1){1'b1}}, 1'b0};
            row_q      <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            hits_q     <= '0;
            code_acc_q <= '0;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            cand_q     <= '0;
            valid_q    <= 1'b0;
            key_code_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            dwell_q    <= dwell_d;
            rows_n_q   <= rows_n_d;
            row_q      <= row_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hits_q     <= hits_d;
            code_acc_q <= code_acc_d;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            cand_q     <= cand_d;
            valid_q    <= valid_d;
            key_code_q <= key_code_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rows_n      = rows_n_q;
    assign key_valid   = valid_q;
    assign key_code    = key_code_q;
    assign key_overrun = overrun_q;
    assign key_down    = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 switch matrix drives the columns; a frame-level
// model (run lengths of frame classes) predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int SP = 8;
    localparam int DF = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NC-1:0] cols_n;
    logic [NR-1:0] rows_n;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_ready = 1'b0;
    logic          key_down;
    logic          key_overrun;
    logic [15:0]   pressed = '0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    keypad_scanner #(
        .NumRows(NR), .NumCols(NC), .ScanPeriod(SP), .DebounceFrames(DF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cols_n(cols_n), .rows_n(rows_n),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .key_down(key_down), .key_overrun(key_overrun)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to its row strobe.
    always_comb begin
        cols_n = '1;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (pressed[r*NC+c] && !rows_n[r]) cols_n[c] = 1'b0;
    end

    // Reference model: cycle index since reset, pin history, frame classes.
    int         c = 0;
    logic [3:0] h1 = '1, h2 = '1;
    int         fq[$];
    int         last_cls = -3, run = 0, multi_frames = 0;
    bit         held = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
    int         m_code = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                c = 0; h1 = '1; h2 = '1; fq.delete();
                last_cls = -3; run = 0; held = 1'b0;
                m_valid = 1'b0; m_ovr = 1'b0; m_code = 0;
            end else begin
                automatic logic [3:0] smp = h2;
                automatic bit emit = 1'b0;
                automatic int cls, row;
                h2 = h1;
                h1 = cols_n;
                if (c % SP == SP - 1) begin
                    row = (c / SP) % NR;
                    for (int k = 0; k < NC; k++) if (!smp[k]) fq.push_back(row*NC + k);
                    if (row == NR - 1) begin
                        cls = (fq.size() == 0) ? -1 : (fq.size() == 1) ? fq[0] : -2;
                        if (cls == -2) multi_frames++;
                        fq.delete();
                        if (cls == last_cls) run++;
                        else begin last_cls = cls; run = 1; end
                        if (!held && cls >= 0 && run == DF) begin
                            emit = 1'b1; held = 1'b1;
                        end else if (held && cls == -1 && run == DF) begin
                            held = 1'b0;
                        end
                    end
                end
                if (emit) begin
                    if (!m_valid || key_ready) begin
                        m_valid = 1'b1; m_code = last_cls; m_ovr = 1'b0;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && key_ready) begin
                    m_valid = 1'b0; m_ovr = 1'b0;
                end
                c++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t cyc=%0d)", nm, got, exp, $time, c);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                automatic logic [3:0] exp_rows = ~(4'd1 << ((c / SP) % NR));
                n_vec++;
                chk("rows_n", 32'(rows_n), 32'(exp_rows));
                chk("key_valid", 32'(key_valid), 32'(m_valid));
                chk("key_code", 32'(key_code), 32'(m_code));
                chk("key_down", 32'(key_down), 32'(held));
                chk("key_overrun", 32'(key_overrun), 32'(m_ovr));
            end
        end
    end

    int valid_cnt = 0;
    bit down_seen = 1'b0;

    task automatic step_to(input int n);
        int guard = 0;
        while (c < n && guard < 20000) begin
            @(negedge clk);
            valid_cnt += int'(key_valid);
            down_seen |= key_down;
            guard++;
        end
        if (c != n) begin
            n_err++;
            $display("FAIL step_to: cycle %0d, expected %0d", c, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst rows_n", 32'(rows_n), 32'(4'b1110));
        chk("rst key_valid", 32'(key_valid), 0);
        chk("rst key_code", 32'(key_code), 0);
        chk("rst key_down", 32'(key_down), 0);
        chk("rst key_overrun", 32'(key_overrun), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        valid_cnt = 0;
        down_seen = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int pts[5];
        logic [3:0] rexp[5];
        pts  = '{7, 8, 16, 24, 32};
        rexp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Free-running row rotation.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step_to(pts[i]);
            chk($sformatf("rows_n@%0d", pts[i]), 32'(rows_n), 32'(rexp[i]));
        end

        // Key 9 held for 5 frames, then released.
        do_reset();
        key_ready = 1'b1;
        pressed = 16'(1) << 9;
        step_to(95);
        chk("press valid@95", 32'(key_valid), 0);
        chk("press down@95", 32'(key_down), 0);
        step_to(96);
        chk("press valid@96", 32'(key_valid), 1);
        chk("press code@96", 32'(key_code), 9);
        chk("press down@96", 32'(key_down), 1);
        step_to(97);
        chk("press valid@97", 32'(key_valid), 0);
        step_to(160);
        #2 pressed = '0;
        step_to(255);
        chk("release down@255", 32'(key_down), 1);
        step_to(256);
        chk("release down@256", 32'(key_down), 0);
        step_to(320);
        chk("press event count", 32'(valid_cnt), 1);

        // Bounce: 2 frames closed, 1 open, four times.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pressed = 16'(1) << 6;
            step_to(i*96 + 64);
            #2 pressed = '0;
            step_to(i*96 + 96);
            #2;
        end
        step_to(448);
        chk("bounce events", 32'(valid_cnt), 0);
        chk("bounce down seen", 32'(down_seen), 0);

        // Keys 0 and 5 together.
        do_reset();
        multi_frames = 0;
        pressed = 16'h0021;
        step_to(192);
        chk("multi frames (model)", 32'(multi_frames), 6);
        chk("multi events", 32'(valid_cnt), 0);
        chk("multi down seen", 32'(down_seen), 0);
        #2 pressed = '0;

        // Backpressure: event 3 pending, event 12 dropped.
        do_reset();
        key_ready = 1'b0;
        pressed = 16'(1) << 3;
        step_to(128);
        #2 pressed = '0;
        step_to(200);
        chk("bp valid@200", 32'(key_valid), 1);
        chk("bp code@200", 32'(key_code), 3);
        chk("bp overrun@200", 32'(key_overrun), 0);
        step_to(256);
        #2 pressed = 16'(1) << 12;
        step_to(351);
        chk("bp overrun@351", 32'(key_overrun), 0);
        step_to(352);
        chk("bp valid@352", 32'(key_valid), 1);
        chk("bp code@352", 32'(key_code), 3);
        chk("bp overrun@352", 32'(key_overrun), 1);
        step_to(380);
        #2 key_ready = 1'b1;
        step_to(381);
        chk("bp valid after accept", 32'(key_valid), 0);
        chk("bp overrun after accept", 32'(key_overrun), 0);
        #2 key_ready = 1'b0;

        // Reset during the second PRESS_DB frame.
        do_reset();
        key_ready = 1'b1;
        pressed = 16'(1) << 10;
        step_to(45);
        do_reset();
        step_to(95);
        chk("rst-restart valid@95", 32'(key_valid), 0);
        step_to(96);
        chk("rst-restart valid@96", 32'(key_valid), 1);
        chk("rst-restart code@96", 32'(key_code), 10);

        // Randomized key patterns and consumer readiness.
        do_reset();
        pressed = '0;
        for (int s = 0; s < 40; s++) begin
            automatic int mode = $urandom_range(0, 3);
            automatic int len = $urandom_range(20, 200);
            automatic int bias = $urandom_range(0, 4);
            automatic logic [15:0] p = '0;
            if (mode == 1 || mode == 2) begin
                p[$urandom_range(0, 15)] = 1'b1;
            end else if (mode == 3) begin
                p[$urandom_range(0, 15)] = 1'b1;
                p[$urandom_range(0, 15)] = 1'b1;
            end
            @(negedge clk);
            #2 pressed = p;
            for (int i = 0; i < len; i++) begin
                key_ready = ($urandom_range(0, 3) < bias);
                @(negedge clk);
                #2;
            end
        end
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
